avs_echo_ctrl: RTL and testbench
================================

AVS_ECHO_CTRL -- requirements
Module: avs_echo_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  AVS_AVALONSLAVE_DATA_WIDTH, 32, register and bus width (>=32)
  AVS_AVALONSLAVE_ADDRESS_WIDTH, 6, byte address width
  NUM_ADDR, 3, number of DMA address registers (1..8)
  NUM_W, 11, width of NUM field
  SIZE_W, 19, width of SIZE field
REQ-002 Ports, one per line (name, direction, width, meaning):
  CSI_CLOCK_CLK  in  1  single clock, all logic rising-edge
  CSI_CLOCK_RESET  in  1  reset, asynchronous, active-high
  AVS_AVALONSLAVE_ADDRESS  in  ADDRESS_WIDTH  byte address; word index = ADDRESS>>2
  AVS_AVALONSLAVE_READ  in  1  read request
  AVS_AVALONSLAVE_WRITE  in  1  write request
  AVS_AVALONSLAVE_BYTEENABLE  in  DATA_WIDTH/8  write byte lanes
  AVS_AVALONSLAVE_WRITEDATA  in  DATA_WIDTH  write data
  AVS_AVALONSLAVE_READDATA  out  DATA_WIDTH  registered read data
  AVS_AVALONSLAVE_WAITREQUEST  out  1  stall
  START  out  1  one-cycle start pulse to datapath
  ABORT  out  1  one-cycle abort pulse to datapath
  DONE  in  1  datapath completion pulse
  NUM  out  NUM_W  echo count
  SIZE  out  SIZE_W  sample count
  ADDR  out  NUM_ADDR*DATA_WIDTH  flat address bus, register k at bits [k*DW +: DW]
  IRQ  out  1  level interrupt

Function
REQ-003 Word map: 0 CTRL (W: bit0 GO, bit1 IRQ_EN, bit2 ABORT_REQ; R: bit1 IRQ_EN, others 0); 1 STATUS (bit0 BUSY RO, bit1 DONE_ST W1C, bit2 ERR_ST W1C); 2 NUM[NUM_W-1:0]; 3 SIZE[SIZE_W-1:0]; 4..4+NUM_ADDR-1 ADDR k.
REQ-004 Unmapped word: read returns 0, write ignored, no error.
REQ-005 Write: zero wait states; WAITREQUEST stays 0; byte lanes with BYTEENABLE=0 unchanged; unused high bits of NUM/SIZE read 0.
REQ-006 Read: WAITREQUEST=1 in first cycle READ is seen, 0 in second cycle with READDATA valid; READDATA holds last value otherwise (never Z).
REQ-007 READ and WRITE asserted together: write performed, read treated as new request per REQ-006.
REQ-008 FSM states IDLE, RUN. IDLE->RUN on CTRL write with GO=1 (byte 0 enabled); START=1 exactly the following cycle.
REQ-009 RUN->IDLE on DONE=1: DONE_ST set same edge; BUSY=1 in RUN only.
REQ-010 RUN->IDLE on CTRL write with ABORT_REQ=1: ABORT=1 next cycle, DONE_ST not set; ABORT_REQ in IDLE ignored.
REQ-011 GO in RUN ignored, ERR_ST set; GO and ABORT_REQ in same write: ABORT wins in RUN, GO wins in IDLE.
REQ-012 Writes to NUM, SIZE, ADDR while BUSY ignored and set ERR_ST.
REQ-013 DONE in IDLE ignored; DONE same cycle as W1C of DONE_ST: set wins.
REQ-014 DONE and ABORT_REQ same cycle in RUN: DONE wins, no ABORT pulse.
REQ-015 NUM, SIZE, ADDR drive outputs directly from registers, stable throughout RUN.

Reset
REQ-016 On CSI_CLOCK_RESET=1 (async): state IDLE, all registers 0, START=ABORT=IRQ=0, WAITREQUEST=0, READDATA=0; in-flight read dropped.
REQ-017 Reset in RUN produces no ABORT pulse; datapath shares reset.

Configuration
REQ-018 Macro AVS_ECHO_CTRL_IRQ_EN defined: IRQ = IRQ_EN & (DONE_ST | ERR_ST), registered; cleared by W1C.
REQ-019 Macro undefined: IRQ tied 0, IRQ_EN bit not stored, reads 0; all other behaviour identical.

Verification
REQ-020 Write NUM=5, SIZE=0x1000, ADDR0..2=0x100/0x200/0x300, CTRL=1 -> START one pulse next cycle, BUSY=1, outputs match written values.
REQ-021 Read STATUS in RUN -> WAITREQUEST 1 then 0, READDATA=0x1; pulse DONE -> READDATA=0x2; write STATUS=0x2 -> reads 0x0.
REQ-022 In RUN write SIZE=0x20 and CTRL=1 -> SIZE unchanged, no START, STATUS=0x5.
REQ-023 In RUN write CTRL=0x4 -> ABORT one pulse, BUSY=0, DONE_ST=0; DONE same cycle as ABORT_REQ -> DONE_ST=1, no ABORT.
REQ-024 With IRQ_EN macro: CTRL=0x3, then DONE -> IRQ=1 next cycle; W1C STATUS=0x2 -> IRQ=0; without macro IRQ stays 0.
REQ-025 Assert reset mid-read in RUN -> outputs zero asynchronously, no ABORT, next read of NUM returns 0.

Source files
------------

// File: rtl/avs_echo_ctrl.sv
// Avalon-MM control/status block for the echo datapath; IRQ output gated by macro AVS_ECHO_CTRL_IRQ_EN.
// Latency: writes take effect on the accepting edge, reads return one cycle after the request.
// Backpressure: one wait state per read; writes never stall.
module avs_echo_ctrl #(
  parameter int AVS_AVALONSLAVE_DATA_WIDTH    = 32,
  parameter int AVS_AVALONSLAVE_ADDRESS_WIDTH = 6,
  parameter int NUM_ADDR                      = 3,
  parameter int NUM_W                         = 11,
  parameter int SIZE_W                        = 19
) (
  input  logic                                           CSI_CLOCK_CLK,
  input  logic                                           CSI_CLOCK_RESET,
  input  logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0]       AVS_AVALONSLAVE_ADDRESS,
  input  logic                                           AVS_AVALONSLAVE_READ,
  input  logic                                           AVS_AVALONSLAVE_WRITE,
  input  logic [AVS_AVALONSLAVE_DATA_WIDTH/8-1:0]        AVS_AVALONSLAVE_BYTEENABLE,
  input  logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]          AVS_AVALONSLAVE_WRITEDATA,
  output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]          AVS_AVALONSLAVE_READDATA,
  output logic                                           AVS_AVALONSLAVE_WAITREQUEST,
  output logic                                           START,
  output logic                                           ABORT,
  input  logic                                           DONE,
  output logic [NUM_W-1:0]                               NUM,
  output logic [SIZE_W-1:0]                              SIZE,
  output logic [NUM_ADDR*AVS_AVALONSLAVE_DATA_WIDTH-1:0] ADDR,
  output logic                                           IRQ
);

  localparam int DW = AVS_AVALONSLAVE_DATA_WIDTH;
  localparam int AW = AVS_AVALONSLAVE_ADDRESS_WIDTH;
  localparam int BW = DW / 8;
  localparam int WW = AW - 2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic            start_d, abort_d, done_set, err_set;
  logic            done_st, err_st, busy, rd_pend;
  logic [NUM_W-1:0]  num_q;
  logic [SIZE_W-1:0] size_q;
  logic [DW-1:0]     addr_q [NUM_ADDR];
  logic [DW-1:0]     rd_mux, num_m, size_m;
  logic [WW-1:0]     word;
  logic              sel_ctrl, sel_stat, sel_num, sel_size;
  logic [NUM_ADDR-1:0] sel_addr;
  logic              ctrl_wr, stat_wr, cfg_wr, go_req, abort_req;
  logic              unused_addr_lsb;

  function automatic logic [DW-1:0] be_merge(input logic [DW-1:0] old_v,
                                             input logic [DW-1:0] new_v,
                                             input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  assign word            = AVS_AVALONSLAVE_ADDRESS[AW-1:2];
  assign unused_addr_lsb = ^AVS_AVALONSLAVE_ADDRESS[1:0];
  assign busy            = (state_q == S_RUN);

  always_comb begin
    sel_ctrl = (word == WW'(0));
    sel_stat = (word == WW'(1));
    sel_num  = (word == WW'(2));
    sel_size = (word == WW'(3));
    sel_addr = '0;
    for (int k = 0; k < NUM_ADDR; k++)
      sel_addr[k] = (word == WW'(4 + k));
  end

  assign ctrl_wr   = AVS_AVALONSLAVE_WRITE & sel_ctrl & AVS_AVALONSLAVE_BYTEENABLE[0];
  assign stat_wr   = AVS_AVALONSLAVE_WRITE & sel_stat & AVS_AVALONSLAVE_BYTEENABLE[0];
  assign cfg_wr    = AVS_AVALONSLAVE_WRITE & (sel_num | sel_size | (|sel_addr));
  assign go_req    = ctrl_wr & AVS_AVALONSLAVE_WRITEDATA[0];
  assign abort_req = ctrl_wr & AVS_AVALONSLAVE_WRITEDATA[2];

  assign num_m  = be_merge(DW'(num_q), AVS_AVALONSLAVE_WRITEDATA, AVS_AVALONSLAVE_BYTEENABLE);
  assign size_m = be_merge(DW'(size_q), AVS_AVALONSLAVE_WRITEDATA, AVS_AVALONSLAVE_BYTEENABLE);

  // DONE outranks a same-cycle abort request; GO+ABORT in RUN is a clean abort, not an error.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    done_set = 1'b0;
    err_set  = cfg_wr & busy;
    case (state_q)
      S_IDLE: begin
        if (go_req) begin
          state_d = S_RUN;
          start_d = 1'b1;
        end
      end
      S_RUN: begin
        if (DONE) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end else if (abort_req) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end
        if (go_req && !abort_req) err_set = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AVS_ECHO_CTRL_IRQ_EN
  logic irq_en_q, irq_q;
  always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
    if (CSI_CLOCK_RESET) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= AVS_AVALONSLAVE_WRITEDATA[1];
      irq_q <= irq_en_q & (done_st | err_st);
    end
  end
  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl) begin
`ifdef AVS_ECHO_CTRL_IRQ_EN
      rd_mux[1] = irq_en_q;
`endif
    end else if (sel_stat) begin
      rd_mux[2:0] = {err_st, done_st, busy};
    end else if (sel_num) begin
      rd_mux[NUM_W-1:0] = num_q;
    end else if (sel_size) begin
      rd_mux[SIZE_W-1:0] = size_q;
    end else begin
      for (int k = 0; k < NUM_ADDR; k++)
        if (sel_addr[k]) rd_mux = addr_q[k];
    end
  end

  // Held in reset the slave must not stall, even with READ asserted.
  assign AVS_AVALONSLAVE_WAITREQUEST = AVS_AVALONSLAVE_READ & ~rd_pend & ~CSI_CLOCK_RESET;

  always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
    if (CSI_CLOCK_RESET) begin
      state_q                  <= S_IDLE;
      START                    <= 1'b0;
      ABORT                    <= 1'b0;
      done_st                  <= 1'b0;
      err_st                   <= 1'b0;
      num_q                    <= '0;
      size_q                   <= '0;
      rd_pend                  <= 1'b0;
      AVS_AVALONSLAVE_READDATA <= '0;
      for (int k = 0; k < NUM_ADDR; k++) addr_q[k] <= '0;
    end else begin
      state_q <= state_d;
      START   <= start_d;
      ABORT   <= abort_d;
      done_st <= done_set | (done_st & ~(stat_wr & AVS_AVALONSLAVE_WRITEDATA[1]));
      err_st  <= err_set  | (err_st  & ~(stat_wr & AVS_AVALONSLAVE_WRITEDATA[2]));
      if (AVS_AVALONSLAVE_WRITE && !busy) begin
        if (sel_num)  num_q  <= num_m[NUM_W-1:0];
        if (sel_size) size_q <= size_m[SIZE_W-1:0];
        for (int k = 0; k < NUM_ADDR; k++)
          if (sel_addr[k])
            addr_q[k] <= be_merge(addr_q[k], AVS_AVALONSLAVE_WRITEDATA, AVS_AVALONSLAVE_BYTEENABLE);
      end
      rd_pend <= AVS_AVALONSLAVE_READ & ~rd_pend;
      if (AVS_AVALONSLAVE_READ && !rd_pend) AVS_AVALONSLAVE_READDATA <= rd_mux;
    end
  end

  for (genvar g = 0; g < NUM_ADDR; g++) begin : g_addr
    assign ADDR[g*DW +: DW] = addr_q[g];
  end

  assign NUM  = num_q;
  assign SIZE = size_q;

endmodule

// File: tb/tb_avs_echo_ctrl.sv
// Directed bench for avs_echo_ctrl; IRQ expectations follow AVS_ECHO_CTRL_IRQ_EN.
module tb_avs_echo_ctrl;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NA = 3;
  localparam int NW = 11;
  localparam int SW = 19;
`ifdef AVS_ECHO_CTRL_IRQ_EN
  localparam logic HAS_IRQ = 1'b1;
`else
  localparam logic HAS_IRQ = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   addr;
  logic            read, write, done;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   wdata, rdata;
  logic            wreq, start, abort, irq;
  logic [NW-1:0]   num;
  logic [SW-1:0]   size;
  logic [NA*DW-1:0] addr_bus;

  int n_tests = 0;
  int n_fail  = 0;
  int abort_cnt = 0;
  int ab0;

  always #5 clk = ~clk;

  avs_echo_ctrl dut (
    .CSI_CLOCK_CLK               (clk),
    .CSI_CLOCK_RESET             (rst),
    .AVS_AVALONSLAVE_ADDRESS     (addr),
    .AVS_AVALONSLAVE_READ        (read),
    .AVS_AVALONSLAVE_WRITE       (write),
    .AVS_AVALONSLAVE_BYTEENABLE  (be),
    .AVS_AVALONSLAVE_WRITEDATA   (wdata),
    .AVS_AVALONSLAVE_READDATA    (rdata),
    .AVS_AVALONSLAVE_WAITREQUEST (wreq),
    .START                       (start),
    .ABORT                       (abort),
    .DONE                        (done),
    .NUM                         (num),
    .SIZE                        (size),
    .ADDR                        (addr_bus),
    .IRQ                         (irq)
  );

  always @(negedge clk) if (abort === 1'b1) abort_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] b);
    @(negedge clk);
    addr = a; wdata = d; be = b; write = 1'b1;
    #1 check("wr_nowait", wreq, 1'b0);
    @(negedge clk);
    write = 1'b0; be = '0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int n;
    @(negedge clk);
    addr = a; read = 1'b1;
    #1 check({tag, "_wait1"}, wreq, 1'b1);
    n = 0;
    while (wreq && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, 1);
    check(tag, rdata, exp);
    read = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; read = 1'b1; write = 1'b0; done = 1'b0; be = '0; wdata = '0;
    #12;
    check("rst_wait",  wreq, 1'b0);
    check("rst_rdata", rdata, 0);
    check("rst_start", start, 1'b0);
    check("rst_abort", abort, 1'b0);
    check("rst_irq",   irq, 1'b0);
    check("rst_num",   num, 0);
    check("rst_size",  size, 0);
    check("rst_addr",  addr_bus, 0);
    read = 1'b0;
    @(negedge clk); rst = 1'b0;

    // unmapped word: read 0, write dropped without error
    wr(6'h30, 32'hFFFF_FFFF, 4'hF);
    rd("unmapped", 6'h30, 32'h0);
    rd("stat_idle", 6'h04, 32'h0);

    // byte lanes and unused high bits of NUM
    wr(6'h08, 32'hFFFF_FFFF, 4'hF);
    rd("num_full", 6'h08, 32'h7FF);
    wr(6'h08, 32'h1234_5605, 4'h1);
    rd("num_be0", 6'h08, 32'h705);

    // configuration then GO
    wr(6'h08, 32'd5, 4'hF);
    wr(6'h0C, 32'h1000, 4'hF);
    wr(6'h10, 32'h100, 4'hF);
    wr(6'h14, 32'h200, 4'hF);
    wr(6'h18, 32'h300, 4'hF);
    wr(6'h00, 32'h1, 4'hF);
    check("go_start", start, 1'b1);
    @(negedge clk);
    check("go_start_once", start, 1'b0);
    check("out_num",  num, 5);
    check("out_size", size, 32'h1000);
    check("out_addr", addr_bus, 96'h00000300_00000200_00000100);
    rd("stat_run", 6'h04, 32'h1);
    pulse_done();
    rd("stat_done", 6'h04, 32'h2);
    wr(6'h04, 32'h2, 4'h1);
    rd("stat_w1c", 6'h04, 32'h0);

    // writes while busy are refused and flagged
    wr(6'h00, 32'h1, 4'hF);
    wr(6'h0C, 32'h20, 4'hF);
    check("busy_size", size, 32'h1000);
    wr(6'h00, 32'h1, 4'hF);
    check("busy_go_nostart", start, 1'b0);
    rd("stat_err", 6'h04, 32'h5);
    wr(6'h04, 32'h6, 4'h1);
    rd("stat_err_clr", 6'h04, 32'h1);

    // abort in RUN, ignored in IDLE, loses to DONE
    wr(6'h00, 32'h4, 4'hF);
    check("abort_pulse", abort, 1'b1);
    @(negedge clk);
    check("abort_once", abort, 1'b0);
    rd("stat_aborted", 6'h04, 32'h0);
    wr(6'h00, 32'h4, 4'hF);
    check("abort_idle", abort, 1'b0);
    wr(6'h00, 32'h1, 4'hF);
    @(negedge clk);
    addr = 6'h00; wdata = 32'h4; be = 4'hF; write = 1'b1; done = 1'b1;
    @(negedge clk);
    write = 1'b0; done = 1'b0; be = '0;
    check("done_beats_abort", abort, 1'b0);
    rd("stat_done_win", 6'h04, 32'h2);
    wr(6'h04, 32'h2, 4'h1);

    // GO+ABORT: GO wins in IDLE, ABORT wins in RUN
    wr(6'h00, 32'h5, 4'hF);
    check("goab_idle_start", start, 1'b1);
    check("goab_idle_abort", abort, 1'b0);
    wr(6'h00, 32'h5, 4'hF);
    check("goab_run_abort", abort, 1'b1);
    check("goab_run_start", start, 1'b0);
    rd("stat_goab", 6'h04, 32'h0);

    pulse_done();
    rd("done_idle", 6'h04, 32'h0);

    // interrupt
    wr(6'h00, 32'h3, 4'hF);
    rd("ctrl_irqen", 6'h00, HAS_IRQ ? 32'h2 : 32'h0);
    check("irq_run", irq, 1'b0);
    pulse_done();
    repeat (2) @(negedge clk);
    check("irq_set", irq, HAS_IRQ);
    wr(6'h04, 32'h2, 4'h1);
    repeat (2) @(negedge clk);
    check("irq_clr", irq, 1'b0);

    // DONE against same-cycle W1C of DONE_ST: set wins
    wr(6'h00, 32'h1, 4'hF);
    @(negedge clk);
    addr = 6'h04; wdata = 32'h2; be = 4'h1; write = 1'b1; done = 1'b1;
    @(negedge clk);
    write = 1'b0; done = 1'b0; be = '0;
    rd("w1c_vs_done", 6'h04, 32'h2);
    wr(6'h04, 32'h2, 4'h1);

    // async reset in the middle of a read while running
    wr(6'h00, 32'h1, 4'hF);
    @(negedge clk);
    addr = 6'h08; read = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_rdata", rdata, 5);
    ab0 = abort_cnt;
    rst = 1'b1;
    #1;
    check("midrd_rdata", rdata, 0);
    check("midrd_wait",  wreq, 1'b0);
    check("midrd_num",   num, 0);
    check("midrd_addr",  addr_bus, 0);
    @(negedge clk); read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_abort", abort_cnt, ab0);
    rd("num_after_rst", 6'h08, 32'h0);
    rd("stat_after_rst", 6'h04, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
